// File: rtl/st1_fetch.sv
// Instruction-fetch stage: holds the PC, drives the instruction-memory address and
// captures the read data after MEM_LATENCY cycles, presenting {pc, inst} to decode.
module st1_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        IF_valid,
    input  logic        next_fetch,
    input  logic [32:0] jbr_bus,
    input  logic [31:0] inst,
    output logic [31:0] inst_addr,
    output logic        IF_over,
    output logic [63:0] IF_ID_bus,
    output logic [31:0] IF_pc,
    output logic [31:0] IF_inst
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] inst_r, inst_next;
    logic [2:0]  cnt, cnt_next;

    logic        jbr_taken;
    logic [31:0] jbr_target;

    assign jbr_taken  = jbr_bus[32];
    assign jbr_target = jbr_bus[31:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            pc     <= RESET_PC;
            inst_r <= 32'd0;
            cnt    <= 3'd0;
        end else begin
            state  <= state_next;
            pc     <= pc_next;
            inst_r <= inst_next;
            cnt    <= cnt_next;
        end
    end

    // next_fetch outranks every transition: it redirects the PC and drops any fetch in flight.
    always_comb begin
        pc_next    = pc;
        state_next = state;
        cnt_next   = cnt;
        inst_next  = inst_r;

        if (next_fetch) begin
            pc_next = jbr_taken ? jbr_target : pc + 32'd4;
        end

        case (state)
            S_IDLE: begin
                if (IF_valid && !next_fetch) begin
                    cnt_next   = 3'd1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (next_fetch || !IF_valid) begin
                    state_next = S_IDLE;
                end else if (cnt == LAT) begin
                    inst_next  = inst;
                    state_next = S_DONE;
                end else begin
                    cnt_next = cnt + 3'd1;
                end
            end
            S_DONE: begin
                if (next_fetch || !IF_valid) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign inst_addr = pc;
    assign IF_over   = (state == S_DONE);
    assign IF_ID_bus = {pc, inst_r};
    assign IF_pc     = pc;
    assign IF_inst   = inst_r;

endmodule

// File: tb/tb_st1_fetch.sv
// Directed bench for st1_fetch: one instance at latency 1 with a combinational memory
// model, one at latency 3 whose read data is driven by hand from the tasks.
module tb_st1_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Instance A: MEM_LATENCY=1, RESET_PC=0
    logic        resetn_a, valid_a, nf_a;
    logic [32:0] jbr_a;
    logic [31:0] inst_a, addr_a, pc_a, ifinst_a;
    logic        over_a;
    logic [63:0] bus_a;

    // Instance B: MEM_LATENCY=3, RESET_PC=0x1000
    logic        resetn_b, valid_b, nf_b;
    logic [32:0] jbr_b;
    logic [31:0] inst_b, addr_b, pc_b, ifinst_b;
    logic        over_b;
    logic [63:0] bus_b;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = 32'h2401_0005;
            32'h0000_0004: mem_word = 32'h2402_000A;
            32'h0000_0008: mem_word = 32'h0041_1820;
            32'h0000_0040: mem_word = 32'h0800_0010;
            default:       mem_word = {16'hDEAD, a[15:0]};
        endcase
    endfunction

    assign inst_a = mem_word(addr_a);

    st1_fetch #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(1)) dut_a (
        .clk(clk), .resetn(resetn_a), .IF_valid(valid_a), .next_fetch(nf_a),
        .jbr_bus(jbr_a), .inst(inst_a), .inst_addr(addr_a), .IF_over(over_a),
        .IF_ID_bus(bus_a), .IF_pc(pc_a), .IF_inst(ifinst_a)
    );

    st1_fetch #(.RESET_PC(32'h0000_1000), .MEM_LATENCY(3)) dut_b (
        .clk(clk), .resetn(resetn_b), .IF_valid(valid_b), .next_fetch(nf_b),
        .jbr_bus(jbr_b), .inst(inst_b), .inst_addr(addr_b), .IF_over(over_b),
        .IF_ID_bus(bus_b), .IF_pc(pc_b), .IF_inst(ifinst_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        n_vec++;
        if (over_a !== 1'b0 || addr_a !== 32'h0 || bus_a !== 64'h0) begin
            n_err++;
            $display("[TB] FAIL reset_initial: over=%b addr=%h bus=%h, want 0/0/0", over_a, addr_a, bus_a);
        end
        resetn_a = 1'b1;
        valid_a  = 1'b1;
        tick();
        resetn_a = 1'b0;
        #1;
        n_vec++;
        if (over_a !== 1'b0 || addr_a !== 32'h0 || bus_a !== 64'h0) begin
            n_err++;
            $display("[TB] FAIL reset_mid_wait: over=%b addr=%h bus=%h, want 0/0/0", over_a, addr_a, bus_a);
        end
        tick();
        resetn_a = 1'b1;
        tick();
        n_vec++;
        if (over_a !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL reset_release_c1: over=%b want 0", over_a);
        end
        tick();
        n_vec++;
        if (over_a !== 1'b1 || bus_a !== {32'h0, 32'h2401_0005}) begin
            n_err++;
            $display("[TB] FAIL reset_release_fetch: over=%b bus=%h, want 1/%h", over_a, bus_a, {32'h0, 32'h2401_0005});
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        for (int r = 1; r <= 2; r++) begin
            exp_pc = 32'(r * 4);
            nf_a  = 1'b1;
            jbr_a = {1'b0, 32'h0000_0040};
            tick();
            nf_a = 1'b0;
            n_vec++;
            if (addr_a !== exp_pc || over_a !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL seq_pc_%0d: addr=%h over=%b, want %h/0", r, addr_a, over_a, exp_pc);
            end
            tick();
            tick();
            n_vec++;
            if (over_a !== 1'b1 || ifinst_a !== mem_word(exp_pc) || pc_a !== exp_pc) begin
                n_err++;
                $display("[TB] FAIL seq_fetch_%0d: over=%b inst=%h pc=%h, want 1/%h/%h",
                         r, over_a, ifinst_a, pc_a, mem_word(exp_pc), exp_pc);
            end
        end
    endtask

    task automatic test_taken_branch();
        nf_a  = 1'b1;
        jbr_a = {1'b1, 32'h0000_0040};
        tick();
        nf_a = 1'b0;
        n_vec++;
        if (pc_a !== 32'h40 || over_a !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL branch_pc: pc=%h over=%b, want 00000040/0", pc_a, over_a);
        end
        tick();
        tick();
        n_vec++;
        if (over_a !== 1'b1 || bus_a !== {32'h40, 32'h0800_0010}) begin
            n_err++;
            $display("[TB] FAIL branch_fetch: over=%b bus=%h, want 1/%h", over_a, bus_a, {32'h40, 32'h0800_0010});
        end
    endtask

    task automatic test_wrap_simultaneous();
        nf_a  = 1'b1;
        jbr_a = {1'b1, 32'hFFFF_FFFC};
        tick();
        jbr_a = {1'b0, 32'h0000_0000};
        n_vec++;
        if (pc_a !== 32'hFFFF_FFFC || over_a !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL wrap_setup: pc=%h over=%b, want fffffffc/0", pc_a, over_a);
        end
        // still in IDLE with IF_valid high and next_fetch high together
        tick();
        nf_a = 1'b0;
        n_vec++;
        if (addr_a !== 32'h0 || over_a !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL wrap_pc: addr=%h over=%b, want 00000000/0", addr_a, over_a);
        end
        tick();
        n_vec++;
        if (over_a !== 1'b0) begin
            n_err++;
            $display("[TB] FAIL simul_idle: over=%b want 0", over_a);
        end
        tick();
        n_vec++;
        if (over_a !== 1'b1 || ifinst_a !== 32'h2401_0005) begin
            n_err++;
            $display("[TB] FAIL simul_fetch: over=%b inst=%h, want 1/24010005", over_a, ifinst_a);
        end
    endtask

    task automatic test_unaligned_and_drop();
        nf_a  = 1'b1;
        jbr_a = {1'b1, 32'h0000_0043};
        tick();
        nf_a = 1'b0;
        n_vec++;
        if (addr_a !== 32'h0000_0043) begin
            n_err++;
            $display("[TB] FAIL unaligned_target: addr=%h want 00000043", addr_a);
        end
        tick();
        tick();
        n_vec++;
        if (over_a !== 1'b1 || ifinst_a !== 32'hDEAD_0043) begin
            n_err++;
            $display("[TB] FAIL unaligned_fetch: over=%b inst=%h, want 1/dead0043", over_a, ifinst_a);
        end
        valid_a = 1'b0;
        tick();
        n_vec++;
        if (over_a !== 1'b0 || pc_a !== 32'h43 || ifinst_a !== 32'hDEAD_0043) begin
            n_err++;
            $display("[TB] FAIL valid_drop: over=%b pc=%h inst=%h, want 0/00000043/dead0043", over_a, pc_a, ifinst_a);
        end
        valid_a = 1'b1;
        tick();
        tick();
        resetn_a = 1'b0;
        #1;
        n_vec++;
        if (over_a !== 1'b0 || addr_a !== 32'h0 || bus_a !== 64'h0) begin
            n_err++;
            $display("[TB] FAIL reset_mid_done: over=%b addr=%h bus=%h, want 0/0/0", over_a, addr_a, bus_a);
        end
    endtask

    task automatic test_latency();
        inst_b  = 32'h1111_1111;
        valid_b = 1'b1;
        #1;
        n_vec++;
        if (over_b !== 1'b0 || addr_b !== 32'h0000_1000) begin
            n_err++;
            $display("[TB] FAIL lat_c0: over=%b addr=%h, want 0/00001000", over_b, addr_b);
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) inst_b = 32'hAAAA_0001;
            n_vec++;
            if (over_b !== 1'b0) begin
                n_err++;
                $display("[TB] FAIL lat_c%0d: over=%b want 0", c, over_b);
            end
        end
        tick();
        inst_b = 32'h2222_2222;
        n_vec++;
        if (over_b !== 1'b1 || ifinst_b !== 32'hAAAA_0001) begin
            n_err++;
            $display("[TB] FAIL lat_c4: over=%b inst=%h, want 1/aaaa0001", over_b, ifinst_b);
        end
        tick();
        n_vec++;
        if (over_b !== 1'b1 || bus_b !== {32'h0000_1000, 32'hAAAA_0001}) begin
            n_err++;
            $display("[TB] FAIL lat_hold: over=%b bus=%h, want 1/%h", over_b, bus_b, {32'h0000_1000, 32'hAAAA_0001});
        end
    endtask

    task automatic test_abort();
        inst_b = 32'hBBBB_0008;
        nf_b   = 1'b1;
        jbr_b  = {1'b0, 32'h0};
        tick();
        nf_b = 1'b0;
        tick();
        tick();
        n_vec++;
        if (over_b !== 1'b0 || addr_b !== 32'h0000_1004) begin
            n_err++;
            $display("[TB] FAIL abort_pre: over=%b addr=%h, want 0/00001004", over_b, addr_b);
        end
        nf_b = 1'b1;
        tick();
        nf_b = 1'b0;
        n_vec++;
        if (over_b !== 1'b0 || ifinst_b !== 32'hAAAA_0001 || addr_b !== 32'h0000_1008) begin
            n_err++;
            $display("[TB] FAIL abort_edge: over=%b inst=%h addr=%h, want 0/aaaa0001/00001008", over_b, ifinst_b, addr_b);
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            n_vec++;
            if (over_b !== 1'b0 || ifinst_b !== 32'hAAAA_0001) begin
                n_err++;
                $display("[TB] FAIL abort_refetch_c%0d: over=%b inst=%h, want 0/aaaa0001", c, over_b, ifinst_b);
            end
        end
        tick();
        n_vec++;
        if (over_b !== 1'b1 || bus_b !== {32'h0000_1008, 32'hBBBB_0008}) begin
            n_err++;
            $display("[TB] FAIL abort_refetch_done: over=%b bus=%h, want 1/%h", over_b, bus_b, {32'h0000_1008, 32'hBBBB_0008});
        end
    endtask

    initial begin
        resetn_a = 1'b0; valid_a = 1'b0; nf_a = 1'b0; jbr_a = '0;
        resetn_b = 1'b0; valid_b = 1'b0; nf_b = 1'b0; jbr_b = '0; inst_b = '0;

        test_reset();
        test_sequential();
        test_taken_branch();
        test_wrap_simultaneous();
        test_unaligned_and_drop();

        resetn_b = 1'b1;
        tick();
        test_latency();
        test_abort();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/st1_fetch.md
# st1_fetch

Instruction-fetch stage of the multi-cycle MIPS CPU, directly upstream of the decode stage. It holds the program counter and drives the instruction-memory address. It waits a configurable synchronous-read latency, then captures the instruction and presents `{pc, inst}` on `IF_ID_bus` with `IF_over` asserted. The PC advances on `next_fetch`, either sequentially (`pc+4`) or to the target carried on decode's 33-bit `jbr_bus`.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value loaded on reset.
- `MEM_LATENCY`, default `1`: cycles from address presentation to valid `inst` data. Legal range is 1..7.

- `clk` — in, 1: single clock; all state updates on the rising edge.
- `resetn` — in, 1: asynchronous, active-low reset.
- `IF_valid` — in, 1: fetch-stage token; high while this stage owns the current instruction slot.
- `next_fetch` — in, 1: one-cycle pulse; advance the PC.
- `jbr_bus` — in, 33: `{jbr_taken, jbr_target[31:0]}` from decode, sampled only when `next_fetch` is high.
- `inst` — in, 32: read data from the synchronous instruction memory.
- `inst_addr` — out, 32: instruction-memory address; equals `pc`.
- `IF_over` — out, 1: captured instruction is valid; fetch is complete.
- `IF_ID_bus` — out, 64: `{pc, inst_r}` to decode.
- `IF_pc` — out, 32: current PC, for display.
- `IF_inst` — out, 32: captured instruction, for display.

## Operation
- **Registers:** `pc[31:0]`, `inst_r[31:0]`, `cnt[2:0]`, and a 2-bit `state` of IDLE, WAIT or DONE.
- **PC update:** on a rising edge with `next_fetch=1`:
  - `pc <= jbr_taken ? jbr_target : pc + 32'd4`.
  - The add wraps modulo 2^32.
  - `jbr_target` is taken verbatim; its low 2 bits are not masked.
  - With `next_fetch=0`, `pc` holds.
- **Address:** `inst_addr = pc`, combinationally. It is stable for the whole WAIT period because `pc` changes only on `next_fetch`.
- **State machine:**
  - IDLE: if `IF_valid=1` and `next_fetch=0`, set `cnt <= 1` and go to WAIT. Otherwise stay in IDLE.
  - WAIT:
    - If `next_fetch=1` or `IF_valid=0`, abort to IDLE; `inst_r` is unchanged.
    - Else if `cnt == MEM_LATENCY`, set `inst_r <= inst` and go to DONE.
    - Else `cnt <= cnt + 1`.
  - DONE: if `next_fetch=1` or `IF_valid=0`, go to IDLE. Otherwise stay; `inst_r` holds.
- **Outputs:**
  - `IF_over = (state == DONE)`, a Moore output with no combinational path from inputs.
  - `IF_ID_bus = {pc, inst_r}`, `IF_pc = pc`, `IF_inst = inst_r`.
- **Simultaneous events:**
  - `next_fetch` has priority over every state transition: the PC update and the return to IDLE happen on the same edge.
  - A new fetch starts no earlier than the following edge, and only if `IF_valid` is high.
- **Reset:** while `resetn=0`, regardless of clock:
  - `pc = RESET_PC`, `inst_r = 0`, `cnt = 0`, state IDLE.
  - Outputs: `IF_over = 0`, `inst_addr = RESET_PC`, `IF_ID_bus = {RESET_PC, 32'd0}`.
  - Reset asserted mid-WAIT or mid-DONE discards the fetch in progress.

## Timing
- **Fetch latency:** `IF_valid` is first seen high in IDLE in cycle 0.
  - WAIT occupies cycles 1..MEM_LATENCY.
  - `inst` is sampled at the end of cycle MEM_LATENCY.
  - `IF_over` is high from cycle MEM_LATENCY+1.
  - Total: MEM_LATENCY+1 cycles. With MEM_LATENCY=1, `IF_over` rises 2 cycles after `IF_valid`.
- **PC after `next_fetch`:** the new `pc` is visible on `inst_addr` and `IF_pc` the cycle after the `next_fetch` pulse.
- **Holding:** `IF_over` and `IF_ID_bus` stay stable while in DONE, until `IF_valid` drops or `next_fetch` arrives.
- **Memory model:** the instruction memory is required to return data for an address held for MEM_LATENCY edges. This block never changes the address mid-WAIT without aborting the fetch.

## Test plan
- **Reset:** assert `resetn=0` mid-WAIT with RESET_PC=0. Expected: immediately `IF_over=0`, `inst_addr=0`, `IF_ID_bus=64'h0`. After release with `IF_valid=1` and memory word[0]=`32'h2401_0005`: `IF_over=1` 2 cycles later, `IF_ID_bus={32'h0, 32'h2401_0005}`.
- **Sequential fetch:** run three fetch/`next_fetch` rounds with `jbr_taken=0`. Expected: `inst_addr` steps 0→4→8, and each captured instruction matches its memory word.
- **Taken branch:** pulse `next_fetch` with `jbr_bus={1'b1, 32'h0000_0040}` while `pc=8`. Expected: `pc=32'h40` next cycle, then the memory word at 0x40 is fetched.
- **Latency:** with MEM_LATENCY=3, raise `IF_valid` at cycle 0. Expected: `IF_over` low in cycles 0-3 and high in cycle 4. A memory model that changes `inst` after the sample edge must not affect `inst_r`.
- **Abort:** pulse `next_fetch` in WAIT with MEM_LATENCY=3, with `IF_valid` held high after the pulse. Expected: state returns to IDLE, `inst_r` is unchanged, `IF_over` never pulses, and a fresh fetch of `pc+4` completes 4 cycles after re-entering IDLE.
- **Wrap and simultaneity:** with `pc=32'hFFFF_FFFC`, pulse `next_fetch` with `jbr_taken=0`. Expected: `pc=0`. Then assert `IF_valid` and `next_fetch` together in IDLE. Expected: the PC updates, state stays IDLE, and the fetch starts on the next edge.
